// File: rtl/ysyx_24070016_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_24070016_lsu
//   Multi-cycle load/store unit between the EXU and a valid/ready data bus.
//   It accepts one access at a time and steers store data into byte lanes with
//   matching write strobes. Load data is extracted from the returned word and
//   sign- or zero-extended. The core is held (busy) until the bus answers, the
//   access times out, or the access is rejected up front.
//
//   FSM: IDLE -> REQ -> WAIT -> DONE -> IDLE
//     IDLE  accepts a request and latches it.
//           Invalid op (or misalign when checked) goes straight to DONE.
//     REQ   bus_req_valid held until bus_req_ready.
//     WAIT  waits for bus_resp_valid.
//     DONE  resp_valid pulses for one cycle.
//
// Parameters
//   TIMEOUT_CYC  cycles spent in REQ+WAIT before forced error completion
//                (0 disables the timeout)
//
// Configuration macro
//   LSU_MISALIGN_CHECK_EN  reject misaligned h/hu/sh and w/sw with resp_err.
//                          When undefined, halfword ignores addr[0] and word
//                          ignores addr[1:0].
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_*               request from the EXU (valid/ready, wen, funct3 op,
//                       byte address, right-aligned store data)
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            error flag, qualified by resp_valid
//   busy                access in flight (state != IDLE)
//   bus_req_*           word-aligned bus request with lane-replicated data
//                       and byte strobes
//   bus_resp_*          bus response: raw word, error flag
// ---------------------------------------------------------------------------
module ysyx_24070016_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,

    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_rdata,
    input  logic        bus_resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned      CNT_W      = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYC);
    localparam logic             TIMEOUT_EN = (TIMEOUT_CYC != 0);

    state_t           state;
    logic             wen_q;
    logic [2:0]       op_q;
    logic [1:0]       off_q;      // effective byte offset of the access
    logic [CNT_W-1:0] cnt;

    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;
    logic             op_bad;
    logic             misalign;
    logic [1:0]       req_off;
    logic [31:0]      st_wdata;
    logic [3:0]       st_wstrb;
    logic [31:0]      lane;
    logic [31:0]      ld_data;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Timeout fires on the TIMEOUT_CYC-th cycle spent in REQ/WAIT.
    assign cnt_inc     = cnt + 1'b1;
    assign timeout_hit = TIMEOUT_EN && (cnt_inc == CNT_LIMIT);

    assign op_bad = (req_op == 3'b011) || (req_op[2:1] == 2'b11);

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Store lane steering; size comes from op[1:0].
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        req_off  = 2'b00;
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
        case (req_op[1:0])
            2'b00: begin
                req_off  = req_addr[1:0];
                st_wdata = {4{req_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_off;
            end
            2'b01: begin
                req_off  = {req_addr[1], 1'b0};
                st_wdata = {2{req_wdata[15:0]}};
                st_wstrb = 4'b0011 << req_off;
            end
            default: begin
                req_off  = 2'b00;
                st_wdata = req_wdata;
                st_wstrb = 4'b1111;
            end
        endcase
        if (!req_wen) begin
            st_wstrb = 4'b0000;
        end
    end

    // Load extraction from the raw bus word.
    assign lane = bus_resp_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_data = lane;
        case (op_q)
            3'b000:  ld_data = {{24{lane[7]}},  lane[7:0]};
            3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_data = {24'd0, lane[7:0]};
            3'b101:  ld_data = {16'd0, lane[15:0]};
            default: ld_data = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state         <= IDLE;
            wen_q         <= 1'b0;
            op_q          <= 3'b000;
            off_q         <= 2'b00;
            cnt           <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_err      <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_wen       <= 1'b0;
            bus_addr      <= 32'd0;
            bus_wdata     <= 32'd0;
            bus_wstrb     <= 4'b0000;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wen_q <= req_wen;
                        op_q  <= req_op;
                        off_q <= req_off;
                        cnt   <= '0;
                        if (op_bad || misalign) begin
                            // Rejected without touching the bus.
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state         <= REQ;
                            bus_req_valid <= 1'b1;
                            bus_wen       <= req_wen;
                            bus_addr      <= {req_addr[31:2], 2'b00};
                            bus_wdata     <= st_wdata;
                            bus_wstrb     <= st_wstrb;
                        end
                    end
                end
                REQ: begin
                    if (timeout_hit) begin
                        bus_req_valid <= 1'b0;
                        state         <= DONE;
                        resp_valid    <= 1'b1;
                        resp_err      <= 1'b1;
                        resp_rdata    <= 32'd0;
                    end else begin
                        cnt <= cnt_inc;
                        if (bus_req_ready) begin
                            bus_req_valid <= 1'b0;
                            state         <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A response in this cycle wins over a timeout in the same cycle.
                    if (bus_resp_valid) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= bus_resp_err;
                        resp_rdata <= (wen_q || bus_resp_err) ? 32'd0 : ld_data;
                    end else if (timeout_hit) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24070016_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24070016_lsu
//   Directed and randomized checks of the load/store unit against a reference
//   model. The model is written from the byte-lane rules in plain arithmetic.
//   The bus side is scripted per access: ready delay, response delay, and an
//   optional stray response during the request handshake.
// ---------------------------------------------------------------------------
module tb_ysyx_24070016_lsu;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;
    logic        bus_resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_24070016_lsu #(.TIMEOUT_CYC(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wen        (req_wen),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .busy           (busy),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_wen        (bus_wen),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_rdata (bus_resp_rdata),
        .bus_resp_err   (bus_resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model of one access, from the size/offset rules.
    function automatic void model(
        input  logic        wen,
        input  logic [2:0]  op,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] rdata,
        input  logic        berr,
        output logic        early,
        output logic [31:0] e_addr,
        output logic [31:0] e_wdata,
        output logic [3:0]  e_wstrb,
        output logic [31:0] e_rdata,
        output logic        e_err
    );
        int          size;
        int          a;
        int          off;
        logic [31:0] mask;
        logic [31:0] val;
        size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        a     = int'(addr[1:0]);
        off   = a - (a % size);
        mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        early = (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((a % size) != 0) early = 1'b1;
`endif
        e_addr  = addr & ~32'd3;
        e_wdata = (size == 1) ? 32'(wdata[7:0]) * 32'h0101_0101 :
                  (size == 2) ? 32'(wdata[15:0]) * 32'h0001_0001 : wdata;
        e_wstrb = wen ? 4'(((32'd1 << size) - 32'd1) << off) : 4'd0;
        val = (rdata >> (8 * off)) & mask;
        if (!op[2] && (size < 4) && ((val & ((mask >> 1) + 32'd1)) != 32'd0)) begin
            val = val | ~mask;
        end
        e_err   = early || berr;
        e_rdata = (early || berr || wen) ? 32'd0 : val;
    endfunction

    task automatic access(
        input logic        wen,
        input logic [2:0]  op,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input int          rdy_dly,
        input int          rsp_dly,
        input logic [31:0] rdata,
        input logic        berr,
        input logic        spur,
        input string       tag
    );
        logic        early;
        logic        e_err;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic [3:0]  e_wstrb;
        model(wen, op, addr, wdata, rdata, berr, early, e_addr, e_wdata, e_wstrb, e_rdata, e_err);

        @(negedge clk);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom();
        req_wdata = $urandom();
        if (early) begin
            check({tag, ".no_bus_req"}, 32'(bus_req_valid), 32'd0);
            check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".resp_err"},   32'(resp_err), 32'd1);
            check({tag, ".resp_rdata"}, resp_rdata, 32'd0);
        end else begin
            check({tag, ".bus_req_valid"}, 32'(bus_req_valid), 32'd1);
            check({tag, ".busy"},          32'(busy), 32'd1);
            check({tag, ".bus_addr"},      bus_addr, e_addr);
            check({tag, ".bus_wen"},       32'(bus_wen), 32'(wen));
            check({tag, ".bus_wstrb"},     32'(bus_wstrb), 32'(e_wstrb));
            if (wen) check({tag, ".bus_wdata"}, bus_wdata, e_wdata);
            repeat (rdy_dly) @(negedge clk);
            if (rdy_dly > 0) begin
                check({tag, ".held_valid"}, 32'(bus_req_valid), 32'd1);
                check({tag, ".held_addr"},  bus_addr, e_addr);
            end
            bus_req_ready = 1'b1;
            if (spur) begin
                bus_resp_valid = 1'b1;
                bus_resp_rdata = $urandom();
                bus_resp_err   = 1'b1;
            end
            @(negedge clk);
            bus_req_ready  = 1'b0;
            bus_resp_valid = 1'b0;
            bus_resp_err   = 1'b0;
            check({tag, ".req_dropped"},  32'(bus_req_valid), 32'd0);
            check({tag, ".no_early_rsp"}, 32'(resp_valid), 32'd0);
            repeat (rsp_dly) @(negedge clk);
            bus_resp_valid = 1'b1;
            bus_resp_rdata = rdata;
            bus_resp_err   = berr;
            @(negedge clk);
            bus_resp_valid = 1'b0;
            bus_resp_err   = 1'b0;
            bus_resp_rdata = $urandom();
            check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".resp_err"},   32'(resp_err), 32'(e_err));
            check({tag, ".resp_rdata"}, resp_rdata, e_rdata);
        end
        @(negedge clk);
        check({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
        check({tag, ".idle_again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic        w;
        logic [2:0]  rop;
        int          r;
        int          got;
        logic [2:0]  load_ops [5];
        load_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst            = 1'b1;
        req_valid      = 1'b0;
        req_wen        = 1'b0;
        req_op         = 3'b000;
        req_addr       = 32'd0;
        req_wdata      = 32'd0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_rdata = 32'd0;
        bus_resp_err   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst.req_ready",     32'(req_ready), 32'd1);
        check("rst.busy",          32'(busy), 32'd0);
        check("rst.resp_valid",    32'(resp_valid), 32'd0);
        check("rst.resp_err",      32'(resp_err), 32'd0);
        check("rst.resp_rdata",    resp_rdata, 32'd0);
        check("rst.bus_req_valid", 32'(bus_req_valid), 32'd0);
        check("rst.bus_addr",      bus_addr, 32'd0);
        check("rst.bus_wdata",     bus_wdata, 32'd0);
        check("rst.bus_wstrb",     32'(bus_wstrb), 32'd0);
        check("rst.bus_wen",       32'(bus_wen), 32'd0);

        // Directed vectors
        access(1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 0, 0, 32'd0,          1'b0, 1'b0, "sw");
        access(1'b0, 3'b000, 32'h8000_0003, 32'd0,         0, 0, 32'h80FF_7F01, 1'b0, 1'b0, "lb");
        access(1'b0, 3'b100, 32'h8000_0003, 32'd0,         0, 0, 32'h80FF_7F01, 1'b0, 1'b0, "lbu");
        access(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 0, 0, 32'd0,          1'b0, 1'b0, "sh");
        access(1'b0, 3'b101, 32'h8000_0002, 32'd0,         0, 0, 32'hABCD_0000, 1'b0, 1'b0, "lhu");
        access(1'b0, 3'b001, 32'h8000_0002, 32'd0,         1, 2, 32'h8001_0000, 1'b0, 1'b1, "lh");
        access(1'b1, 3'b000, 32'h8000_0001, 32'h0000_005A, 2, 1, 32'd0,          1'b0, 1'b0, "sb");
        access(1'b0, 3'b010, 32'h8000_0001, 32'd0,         0, 0, 32'h1122_3344, 1'b0, 1'b0, "lw_mis");
        access(1'b0, 3'b010, 32'h8000_0008, 32'd0,         0, 0, 32'h5555_AAAA, 1'b1, 1'b0, "lw_berr");
        access(1'b0, 3'b011, 32'h8000_0000, 32'd0,         0, 0, 32'd0,          1'b0, 1'b0, "bad_op");
        // Response lands on the last cycle before timeout: response wins.
        access(1'b0, 3'b010, 32'h8000_0010, 32'd0,         3, 3, 32'hCAFE_F00D, 1'b0, 1'b0, "rsp_vs_to");

        // Timeout: bus never ready
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_op    = 3'b010;
        req_addr  = 32'h8000_0020;
        got = 0;
        for (int k = 1; k <= 40 && got == 0; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) got = k;
        end
        check("to.latency",       32'(got), 32'(TO + 1));
        check("to.resp_err",      32'(resp_err), 32'd1);
        check("to.resp_rdata",    resp_rdata, 32'd0);
        check("to.bus_req_valid", 32'(bus_req_valid), 32'd0);
        @(negedge clk);
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'h1234_5678;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        check("to.late_ignored", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("to.late_idle", 32'(resp_valid), 32'd0);

        // Reset while waiting for the response
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_op    = 3'b010;
        req_addr  = 32'h8000_0030;
        @(negedge clk);
        req_valid     = 1'b0;
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        check("rstw.in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw.req_ready",  32'(req_ready), 32'd1);
        check("rstw.busy",       32'(busy), 32'd0);
        check("rstw.resp_valid", 32'(resp_valid), 32'd0);
        bus_resp_valid = 1'b1;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        check("rstw.late_ignored", 32'(resp_valid), 32'd0);

        // Reset while requesting
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_op    = 3'b010;
        req_addr  = 32'h8000_0040;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstr.bus_req_valid", 32'(bus_req_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstr.req_dropped", 32'(bus_req_valid), 32'd0);
        check("rstr.resp_valid",  32'(resp_valid), 32'd0);

        // Randomized accesses
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 2) begin
                w   = 1'($urandom_range(0, 1));
                rop = (r == 0) ? 3'b011 : 3'($urandom_range(6, 7));
            end else if (r < 9) begin
                w   = 1'b1;
                rop = 3'($urandom_range(0, 2));
            end else begin
                w   = 1'b0;
                rop = load_ops[$urandom_range(0, 4)];
            end
            access(w, rop, $urandom(), $urandom(),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   $urandom(), ($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 1)), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
